// File: rtl/univ_shift_pkg.sv
// -----------------------------------------------------------------------------
// univ_shift_pkg
//
// Shared definitions for the universal shift register:
//   - MODE_* : 3-bit operation codes applied to the register on a ce=1 edge
//   - state_t: burst-engine FSM states (IDLE, RUN, FIN); the encoding is also
//              what appears on the top level's state_dbg output
//   - is_shift_mode(): true for the modes a burst is allowed to repeat
// -----------------------------------------------------------------------------
package univ_shift_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;  // q unchanged
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b001;  // shift right, sr_in -> MSB
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;  // shift left, sl_in -> LSB
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b011;  // parallel load from d
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'b100;  // rotate right
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'b101;  // rotate left
    localparam logic [MODE_W-1:0] MODE_ASR  = 3'b110;  // arithmetic shift right
    localparam logic [MODE_W-1:0] MODE_CLR  = 3'b111;  // synchronous clear

    // Explicit values so state_dbg has a stable, documented meaning.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // HOLD, LOAD and CLR are not repeatable steps; a burst request with one
    // of them completes immediately without touching q.
    function automatic logic is_shift_mode(input logic [MODE_W-1:0] m);
        logic r;
        r = 1'b0;
        case (m)
            MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASR: r = 1'b1;
            default:                                          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage : univ_shift_pkg

// File: rtl/univ_shift_next.sv
// -----------------------------------------------------------------------------
// univ_shift_next
//
// Purely combinational next-value selector for the shift register. The top
// level feeds it either the live mode (IDLE) or the latched burst mode (RUN),
// so a single mux serves both paths.
//
// Ports:
//   mode   in  [2:0]       operation code (MODE_* from univ_shift_pkg)
//   q      in  [WIDTH-1:0] current register value; q[WIDTH-1] is the MSB/QA end
//   d      in  [WIDTH-1:0] parallel load data
//   sr_in  in  1           serial input entering q[WIDTH-1] on SHR
//   sl_in  in  1           serial input entering q[0] on SHL
//   q_next out [WIDTH-1:0] value q takes if this operation is applied
// -----------------------------------------------------------------------------
module univ_shift_next
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8   // minimum 2: the shift slices need q[WIDTH-2:0]
) (
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  q,
    input  logic [WIDTH-1:0]  d,
    input  logic              sr_in,
    input  logic              sl_in,
    output logic [WIDTH-1:0]  q_next
);

    always_comb begin
        q_next = q;
        case (mode)
            MODE_HOLD: q_next = q;
            MODE_SHR:  q_next = {sr_in, q[WIDTH-1:1]};
            MODE_SHL:  q_next = {q[WIDTH-2:0], sl_in};
            MODE_LOAD: q_next = d;
            MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            // Sign bit is replicated, so negative values stay negative.
            MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            MODE_CLR:  q_next = '0;
            default:   q_next = q;
        endcase
    end

endmodule : univ_shift_next

// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
//
// Parametrised universal shift register with a counted burst engine.
// Outside a burst the register applies `mode` on every ce=1 edge. A burst
// repeats one shift-type operation `len` times on its own, then pulses done.
//
// Burst handshake (single description for all three signals):
//   start is sampled only while the engine is idle (busy=0, done=0), on any
//   edge regardless of ce. A shift-type mode with len!=0 is accepted: busy
//   rises after that edge and stays high until the last step has been applied
//   (ce=0 cycles stretch it, steps only happen on ce=1). Any other request is
//   accepted as an empty burst. Either way, done is high for exactly one
//   cycle after the burst ends, busy is low during that cycle, and start is
//   ignored while busy or done is high. rst aborts a burst without done.
//
// Ports:
//   clk       in  1           rising-edge clock
//   rst       in  1           synchronous active-high reset, overrides all
//   ce        in  1           clock enable; 0 holds q and the burst counter
//   mode      in  [2:0]       operation select (MODE_* in univ_shift_pkg)
//   sr_in     in  1           serial-in for shift right (enters q[WIDTH-1])
//   sl_in     in  1           serial-in for shift left  (enters q[0])
//   d         in  [WIDTH-1:0] parallel load data
//   start     in  1           burst request
//   len       in  [CNT_W-1:0] burst length in shift steps
//   q         out [WIDTH-1:0] register contents, q[WIDTH-1] is the MSB end
//   busy      out 1           high while a burst is running
//   done      out 1           one-cycle pulse when a burst completes
//   state_dbg out [1:0]       current FSM state (state_t encoding)
// -----------------------------------------------------------------------------
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8,   // minimum 2
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic [MODE_W-1:0]  mode,
    input  logic               sr_in,
    input  logic               sl_in,
    input  logic [WIDTH-1:0]   d,
    input  logic               start,
    input  logic [CNT_W-1:0]   len,
    output logic [WIDTH-1:0]   q,
    output logic               busy,
    output logic               done,
    output logic [1:0]         state_dbg
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state;
    logic [MODE_W-1:0]  run_mode;   // operation frozen at burst start
    logic [CNT_W-1:0]   cnt;        // steps still to apply in RUN
    logic [MODE_W-1:0]  sel_mode;
    logic [WIDTH-1:0]   q_next;

    // In RUN the live mode input is ignored; the latched one drives the mux.
    assign sel_mode  = (state == ST_RUN) ? run_mode : mode;
    assign state_dbg = state;

    univ_shift_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .mode   (sel_mode),
        .q      (q),
        .d      (d),
        .sr_in  (sr_in),
        .sl_in  (sl_in),
        .q_next (q_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            q        <= '0;
            cnt      <= '0;
            run_mode <= MODE_HOLD;
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        // q is deliberately left alone on the start edge,
                        // even when ce=1: the request takes priority.
                        if (is_shift_mode(mode) && (len != '0)) begin
                            run_mode <= mode;
                            cnt      <= len;
                            state    <= ST_RUN;
                            busy     <= 1'b1;
                        end else begin
                            state    <= ST_FIN;
                            done     <= 1'b1;
                        end
                    end else if (ce) begin
                        q <= q_next;
                    end
                end

                ST_RUN: begin
                    if (ce) begin
                        q   <= q_next;
                        cnt <= cnt - CNT_ONE;
                        // Last step: busy drops and done rises on the same edge,
                        // so the two outputs never overlap.
                        if (cnt == CNT_ONE) begin
                            state <= ST_FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end

                ST_FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_reg
//
// Drives univ_shift_reg (WIDTH=8, CNT_W=4) with directed sequences followed by
// random traffic. The driver updates a behavioural model each cycle and pushes
// the expected post-edge outputs into exp_q; the monitor pops one entry after
// every rising edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int CW = 4;
    localparam int EW = W + 4;   // {q, state, busy, done}

    // ---------------- clock / reset block ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, ce, start, sr_in, sl_in;
    logic [2:0]    mode;
    logic [W-1:0]  d;
    logic [CW-1:0] len;
    logic [W-1:0]  q;
    logic          busy, done;
    logic [1:0]    state_dbg;

    univ_shift_reg #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .mode      (mode),
        .sr_in     (sr_in),
        .sl_in     (sl_in),
        .d         (d),
        .start     (start),
        .len       (len),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- behavioural reference model ----------------
    // Plain integer arithmetic on the register value.
    int unsigned m_q       = 0;
    int          m_steps   = 0;   // shifts left in the current burst
    bit          m_running = 0;
    bit          m_fin     = 0;
    int unsigned m_op      = 0;

    function automatic int unsigned ref_op(input int unsigned md, input int unsigned v,
                                           input int unsigned dd, input bit s_r, input bit s_l);
        int unsigned top, mask, x;
        top  = 1 << (W - 1);
        mask = (1 << W) - 1;
        x    = v;
        case (md)
            1:       x = (v / 2) + (s_r ? top : 0);
            2:       x = ((v * 2) & mask) + s_l;
            3:       x = dd & mask;
            4:       x = (v / 2) + ((v % 2) * top);
            5:       x = ((v * 2) & mask) + (v / top);
            6:       x = (v / 2) + ((v >= top) ? top : 0);
            7:       x = 0;
            default: x = v;
        endcase
        return x;
    endfunction

    function automatic bit ref_is_shift(input int unsigned md);
        return (md == 1) || (md == 2) || (md == 4) || (md == 5) || (md == 6);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input bit r, input bit c, input int unsigned md, input bit st,
                         input int unsigned ln, input int unsigned dd,
                         input bit s_r, input bit s_l);
        logic [1:0] st_code;
        logic [W-1:0] qv;
        @(negedge clk);
        rst   = r;
        ce    = c;
        mode  = md[2:0];
        start = st;
        len   = ln[CW-1:0];
        d     = dd[W-1:0];
        sr_in = s_r;
        sl_in = s_l;

        if (r) begin
            m_q = 0; m_steps = 0; m_running = 0; m_fin = 0;
        end else if (m_running) begin
            if (c) begin
                m_q     = ref_op(m_op, m_q, dd, s_r, s_l);
                m_steps = m_steps - 1;
                if (m_steps == 0) begin
                    m_running = 0;
                    m_fin     = 1;
                end
            end
        end else if (m_fin) begin
            m_fin = 0;
        end else if (st) begin
            if (ref_is_shift(md) && (ln % (1 << CW)) != 0) begin
                m_running = 1;
                m_steps   = ln % (1 << CW);
                m_op      = md;
            end else begin
                m_fin = 1;
            end
        end else if (c) begin
            m_q = ref_op(md, m_q, dd, s_r, s_l);
        end

        st_code = m_running ? 2'd1 : (m_fin ? 2'd2 : 2'd0);
        qv      = m_q[W-1:0];
        exp_q.push_back({qv, st_code, m_running, m_fin});
    endtask

    task automatic op(input int unsigned md, input int unsigned dd, input bit s_r, input bit s_l);
        drive(0, 1, md, 0, 0, dd, s_r, s_l);
    endtask

    task automatic idle_cycles(input int n, input bit c);
        for (int i = 0; i < n; i++)
            drive(0, c, $urandom_range(0, 7), 0, $urandom_range(0, 15), $urandom, 0, 0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [EW-1:0] e, got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {q, state_dbg, busy, done};
                n_checks++;
                if (got === e) n_pass++;
                else $display("FAIL cycle_check t=%0t got q=%h st=%0d busy=%b done=%b required q=%h st=%0d busy=%b done=%b",
                              $time, got[EW-1:4], got[3:2], got[1], got[0],
                              e[EW-1:4], e[3:2], e[1], e[0]);
                n_checks++;
                if (!(busy && done)) n_pass++;
                else $display("FAIL busy_done_overlap t=%0t got busy=%b done=%b required not both 1",
                              $time, busy, done);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1; ce = 0; mode = 0; start = 0; len = 0; d = 0; sr_in = 0; sl_in = 0;

        // reset, with ce/start/mode active to show rst wins
        drive(1, 1, 3, 1, 5, 8'hAA, 1, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0);

        // SHR with sr_in=1 fills from the MSB, then reset clears
        for (int i = 0; i < 4; i++) op(1, 0, 1, 0);
        drive(1, 1, 1, 0, 0, 0, 1, 0);

        // SHL with sl_in=1, LOAD, HOLD, SHR with sr_in=0
        for (int i = 0; i < 4; i++) op(2, 0, 0, 1);
        op(3, 8'h80, 0, 0);
        op(0, 8'hFF, 1, 1);
        op(0, 8'h00, 1, 1);
        op(1, 0, 0, 0);
        op(1, 0, 0, 0);

        // rotates, ASR on a negative value, CLR, ce=0 hold
        op(3, 8'h81, 0, 0);
        op(5, 0, 0, 0);
        op(4, 0, 0, 0);
        op(4, 0, 0, 0);
        op(3, 8'h80, 0, 0);
        for (int i = 0; i < 3; i++) op(6, 0, 0, 0);
        op(3, 8'h5A, 0, 0);
        for (int m = 0; m < 8; m++) drive(0, 0, m, 0, 0, 8'hFF, 1, 1);
        op(7, 0, 0, 0);

        // ROL burst of 3 from 0x01; live mode toggles during RUN
        op(3, 8'h01, 0, 0);
        drive(0, 1, 5, 1, 3, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, i, 1, 0, 8'hFF, 1, 1);
        drive(0, 1, 3, 1, 7, 8'hEE, 0, 0);   // start ignored in FIN
        idle_cycles(2, 0);

        // len=0 and non-shift mode: immediate FIN, q untouched
        drive(0, 1, 4, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 3, 1, 5, 8'h33, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // start recognised with ce=0; len=5 with 2 stalled cycles
        op(3, 8'h96, 0, 0);
        drive(0, 0, 1, 1, 5, 0, 1, 0);
        drive(0, 1, 0, 0, 0, 0, 1, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 1, 0, 0, 0, 0, 1, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 1, 0);
        idle_cycles(2, 0);

        // same burst aborted by rst in the 3rd RUN cycle: no done
        op(3, 8'h96, 0, 0);
        drive(0, 1, 1, 1, 5, 0, 1, 0);
        drive(0, 1, 0, 0, 0, 0, 1, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 1, 0);
        idle_cycles(3, 0);

        // len > WIDTH: ROR by 9 equals ROR by 1
        op(3, 8'hB1, 0, 0);
        drive(0, 1, 4, 1, 9, 0, 0, 0);
        idle_cycles(11, 1);

        // ASR burst of max length
        op(3, 8'h90, 0, 0);
        drive(0, 1, 6, 1, 15, 0, 0, 0);
        idle_cycles(17, 1);

        // random traffic
        for (int i = 0; i < 800; i++)
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 5) == 0,
                  $urandom_range(0, 15), $urandom, $urandom_range(0, 1),
                  $urandom_range(0, 1));

        // let the monitor drain the queue, bounded
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL queue_drain got %0d entries left required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_univ_shift_reg

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register; successor to the 4-bit 74LS194-style block used in the shift experiments.
- Generalises width, adds rotate, arithmetic-shift and synchronous-clear modes, and adds a counted burst engine.
- The burst engine shifts a programmed number of steps autonomously, then pulses done.
- Sits between board I/O (switches/LEDs) and serial-link or LED-marquee logic.

Parameters:
- WIDTH, 8, register width in bits; minimum 2.
- CNT_W, 4, width of the burst length field len.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset.
- ce  input  1  clock enable; when 0, q and the burst counter hold.
- mode  input  3  operation select; encodings are listed under Behaviour.
- sr_in  input  1  serial-in for shift right; enters q[WIDTH-1].
- sl_in  input  1  serial-in for shift left; enters q[0].
- d  input  WIDTH  parallel load data.
- start  input  1  burst request; sampled in IDLE only.
- len  input  CNT_W  burst length in shift steps.
- q  output  WIDTH  register contents; q[WIDTH-1] is the QA/MSB end.
- busy  output  1  high while a burst is running.
- done  output  1  one-cycle pulse when a burst completes.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset outputs:
  - With rst=1 at a rising edge: q=0, busy=0, done=0, counter=0, state=IDLE.
  - rst overrides ce, start and mode.
  - rst asserted mid-burst aborts the burst; no done pulse is produced.
- Mode encodings; each takes effect per ce=1 edge:
  - 000 HOLD: q unchanged.
  - 001 SHR: q <= {sr_in, q[W-1:1]}.
  - 010 SHL: q <= {q[W-2:0], sl_in}.
  - 011 LOAD: q <= d.
  - 100 ROR: q <= {q[0], q[W-1:1]}.
  - 101 ROL: q <= {q[W-2:0], q[W-1]}.
  - 110 ASR: q <= {q[W-1], q[W-1:1]}.
  - 111 CLR: q <= 0.
- Shift-type modes are 001, 010, 100, 101 and 110.
- FSM has three states: IDLE, RUN, FIN.
- IDLE:
  - Applies mode directly on every ce=1 cycle.
  - start=1 with a shift-type mode and len!=0:
    - Latches the mode into run_mode and len into cnt.
    - Goes to RUN; q is not modified on the start edge.
  - start=1 with len=0 or a non-shift mode: goes to FIN with no change to q.
  - start is recognised regardless of ce.
- RUN:
  - busy=1.
  - Each ce=1 edge applies run_mode once and decrements cnt.
  - sr_in and sl_in are sampled live each step.
  - The edge that takes cnt from 1 to 0 moves to FIN.
  - With ce=0, q and cnt hold and the state stays RUN.
  - mode, d and start are ignored while in RUN.
- FIN:
  - done=1 for exactly one cycle, busy=0, q holds.
  - Returns unconditionally to IDLE.
  - start is ignored while in FIN.
- Latency:
  - A burst of len=N with ce held high gives busy high for N cycles.
  - done is high in cycle N+1 after the start edge.
- len greater than WIDTH is legal: it shifts len steps (e.g. ROR by WIDTH+1 equals ROR by 1).
- busy and done are registered outputs and are never high together.

Decomposition:
- Package univ_shift_pkg:
  - mode localparams MODE_HOLD ... MODE_CLR.
  - FSM state encodings ST_IDLE, ST_RUN, ST_FIN.
  - helper function is_shift_mode.
- Sub-module univ_shift_next: purely combinational next-value mux.
  - Inputs: mode, q, d, sr_in, sl_in.
  - Output: q_next.
  - Shared by the direct path and the burst path.
- Top level holds the q register, cnt and the FSM.

Test Plan:
- WIDTH=4, SHR with sr_in=1 for 4 edges from q=0000 -> q=1000, 1100, 1110, 1111; then rst=1 for one edge -> q=0000, busy=0, done=0.
- WIDTH=4, SHL with sl_in=1 for 4 edges -> q=0001, 0011, 0111, 1111; then LOAD with d=1000 -> 1000; HOLD for 2 edges -> 1000 kept; SHR with sr_in=0 -> 0100, 0010.
- WIDTH=8, LOAD with d=0x81, then ROL x1 -> 0x03; ROR x2 -> 0xC0; ASR on 0x80 x3 -> 0xF0; CLR -> 0x00; ce=0 with any mode -> q unchanged.
- WIDTH=8, q=0x01, start with ROL and len=3, ce=1 -> busy=1 for 3 cycles, q=0x02, 0x04, 0x08; done=1 on the next cycle; mode toggled during RUN has no effect.
- Burst with len=0 -> done pulse one cycle after start, busy never 1, q unchanged; start with mode=LOAD and len=5 -> immediate FIN, q unchanged.
- Burst of len=5 with ce deasserted for 2 cycles mid-run -> busy lasts 7 cycles, exactly 5 shifts.
- Same burst with rst asserted in the 3rd RUN cycle -> q=0, state IDLE, no done pulse.
